// File: rtl/switch_arb_pkg.sv
// Shared types and helpers for the switch input arbiter.
package switch_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int STATS_CNT_W = 16;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/switch_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after last_ptr, with wrap.
module rr_pick
  import switch_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [idx_w(NUM_REQ)-1:0]   last_ptr,
  output logic                        found,
  output logic [idx_w(NUM_REQ)-1:0]   idx
);

  localparam int IW = idx_w(NUM_REQ);

  always_comb begin
    int cand;
    logic [IW-1:0] c;
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    c     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_ptr) + k) % NUM_REQ;
      c    = IW'(cand);
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = c;
      end
    end
  end

endmodule

// File: rtl/switch_arbiter.sv
// Round-robin, burst-locked arbiter feeding the address-split switch input.
// Optional per-requester transfer counters when SWITCH_ARB_STATS_EN is defined.
module switch_arbiter
  import switch_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           en,
  input  logic [NUM_REQ-1:0]             req_vld,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_rdy,
  output logic                           out_vld,
  output logic [ADDR_WIDTH-1:0]          out_addr,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [idx_w(NUM_REQ)-1:0]      gnt_id,
  output logic                           busy
`ifdef SWITCH_ARB_STATS_EN
  ,
  input  logic                           stats_clr,
  output logic [NUM_REQ*STATS_CNT_W-1:0] grant_cnt
`endif
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int BW = idx_w(MAX_BURST);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_REQ  = IW'(NUM_REQ - 1);

  state_t                  state, state_n;
  logic [IW-1:0]           last_ptr, last_ptr_n;
  logic [IW-1:0]           gnt_n;
  logic [BW-1:0]           beat_cnt, beat_n;
  logic                    found;
  logic [IW-1:0]           pick;
  logic                    owner_vld;
  logic [ADDR_WIDTH-1:0]   owner_addr;
  logic [DATA_WIDTH-1:0]   owner_data;
  logic                    xfer;

  logic                    vld_p1;
  logic [ADDR_WIDTH-1:0]   addr_p1;
  logic [DATA_WIDTH-1:0]   data_p1;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req      (req_vld),
    .last_ptr (last_ptr),
    .found    (found),
    .idx      (pick)
  );

  always_comb begin
    owner_vld  = 1'b0;
    owner_addr = '0;
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == IW'(i)) begin
        owner_vld  = req_vld[i];
        owner_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign busy = (state == BURST);
  assign xfer = busy && en && owner_vld;

  always_comb begin
    req_rdy = '0;
    if (busy && en) req_rdy[gnt_id] = 1'b1;
  end

  // A paused burst (en low) keeps its grant and beat count even if the owner drops valid.
  always_comb begin
    state_n    = state;
    last_ptr_n = last_ptr;
    gnt_n      = gnt_id;
    beat_n     = beat_cnt;
    case (state)
      IDLE: begin
        if (en && found) begin
          state_n = BURST;
          gnt_n   = pick;
          beat_n  = '0;
        end
      end
      BURST: begin
        if (en) begin
          if (owner_vld && beat_cnt != LAST_BEAT) begin
            beat_n = beat_cnt + BW'(1);
          end else begin
            last_ptr_n = gnt_id;
            beat_n     = '0;
            state_n    = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      last_ptr <= LAST_REQ;
      gnt_id   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      last_ptr <= last_ptr_n;
      gnt_id   <= gnt_n;
      beat_cnt <= beat_n;
    end
  end

  // Stage p1: registered beat presented to the switch one cycle after the handshake.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= xfer;
      if (xfer) begin
        addr_p1 <= owner_addr;
        data_p1 <= owner_data;
      end
    end
  end

  assign out_vld  = vld_p1;
  assign out_addr = addr_p1;
  assign out_data = data_p1;

`ifdef SWITCH_ARB_STATS_EN
  logic [STATS_CNT_W-1:0] cnt [NUM_REQ];

  // Clear takes priority over a coincident transfer; counters stick at all-ones.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rstn || stats_clr) begin
        cnt[i] <= '0;
      end else if (xfer && gnt_id == IW'(i) && cnt[i] != '1) begin
        cnt[i] <= cnt[i] + STATS_CNT_W'(1);
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt[i*STATS_CNT_W +: STATS_CNT_W] = cnt[i];
    end
  end
`endif

endmodule
